// File: rtl/hub75_scan_driver.sv
// HUB75 scan driver: walks rows, BCM planes and columns, fetches top/bottom
// pixel pairs from the frame RAM, shifts them onto the panel, latches the row
// and shows each plane for a binary-weighted time gated by OE.
module hub75_scan_driver #(
    parameter int PANEL_WIDTH = 64,
    parameter int ROW_ADDR_W  = 3,
    parameter int BIT_DEPTH   = 4,
    parameter int BASE_TICKS  = 32
) (
    input  logic                  clk_in,
    input  logic                  n_reset_in,
    input  logic                  enable_in,
    output logic                  ram_en_out,
    output logic [15:0]           ram_addr_out,
    input  logic [23:0]           ram_data_in,
    output logic                  r1_out,
    output logic                  g1_out,
    output logic                  b1_out,
    output logic                  r2_out,
    output logic                  g2_out,
    output logic                  b2_out,
    output logic                  bclk_out,
    output logic                  lat_out,
    output logic                  oe_n_out,
    output logic [ROW_ADDR_W-1:0] row_addr_out,
    output logic                  frame_done_out
);

    localparam int SCAN_ROWS = 2 ** ROW_ADDR_W;
    localparam int COL_W     = $clog2(PANEL_WIDTH);
    localparam int PLANE_W   = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
    localparam int DISP_MAX  = BASE_TICKS << (BIT_DEPTH - 1);
    localparam int DISP_W    = $clog2(DISP_MAX + 1);

    localparam logic [COL_W-1:0]      COL_LAST   = COL_W'(PANEL_WIDTH - 1);
    localparam logic [PLANE_W-1:0]    PLANE_LAST = PLANE_W'(BIT_DEPTH - 1);
    localparam logic [ROW_ADDR_W-1:0] ROW_LAST   = ROW_ADDR_W'(SCAN_ROWS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COL_TOP = 3'd1,
        ST_COL_BOT = 3'd2,
        ST_COL_DRV = 3'd3,
        ST_COL_CLK = 3'd4,
        ST_LATCH   = 3'd5,
        ST_DISPLAY = 3'd6,
        ST_BLANK   = 3'd7
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [COL_W-1:0]        col_r;
    logic [COL_W-1:0]        col_s;
    logic [PLANE_W-1:0]      plane_r;
    logic [PLANE_W-1:0]      plane_s;
    logic [ROW_ADDR_W-1:0]   row_r;
    logic [ROW_ADDR_W-1:0]   row_s;
    logic [DISP_W-1:0]       disp_cnt_r;
    logic [DISP_W-1:0]       disp_cnt_s;
    logic [DISP_W-1:0]       disp_target_s;
    logic                    disp_last_s;
    logic [23:0]             top_r;
    logic [2:0]              bit_idx_s;

    logic                    ram_en_s;
    logic [15:0]             ram_addr_s;
    logic [15:0]             top_addr_s;
    logic [15:0]             bot_addr_s;
    logic                    bclk_s;
    logic                    lat_s;
    logic                    oe_n_s;
    logic [ROW_ADDR_W-1:0]   row_addr_s;
    logic                    frame_done_s;

    // Select one channel bit of a pixel; ch 2=R, 1=G, 0=B, idx = bit within channel.
    function automatic logic plane_bit(input logic [23:0] px, input logic [1:0] ch,
                                       input logic [2:0] idx);
        plane_bit = px[{ch, idx}];
    endfunction

    // The plane uses the top BIT_DEPTH bits of each channel, LSB plane first.
    assign bit_idx_s     = 3'(8 - BIT_DEPTH) + 3'(plane_r);
    assign disp_target_s = DISP_W'(BASE_TICKS) << plane_r;
    assign disp_last_s   = (disp_cnt_r == (disp_target_s - DISP_W'(1)));

    // Addresses are formed from the next-cycle counters so they land with the state.
    assign top_addr_s = 16'(row_s) * 16'(PANEL_WIDTH) + 16'(col_s);
    assign bot_addr_s = (16'(row_s) + 16'(SCAN_ROWS)) * 16'(PANEL_WIDTH) + 16'(col_s);

    // State and scan-counter registers.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_r    <= ST_IDLE;
            col_r      <= COL_W'(0);
            plane_r    <= PLANE_W'(0);
            row_r      <= ROW_ADDR_W'(0);
            disp_cnt_r <= DISP_W'(0);
        end else begin
            state_r    <= state_s;
            col_r      <= col_s;
            plane_r    <= plane_s;
            row_r      <= row_s;
            disp_cnt_r <= disp_cnt_s;
        end
    end

    // Next-state and counter sequencing: columns inside planes inside rows.
    always_comb begin
        state_s    = state_r;
        col_s      = col_r;
        plane_s    = plane_r;
        row_s      = row_r;
        disp_cnt_s = disp_cnt_r;
        case (state_r)
            ST_IDLE: begin
                col_s      = COL_W'(0);
                plane_s    = PLANE_W'(0);
                row_s      = ROW_ADDR_W'(0);
                disp_cnt_s = DISP_W'(0);
                if (enable_in) begin
                    state_s = ST_COL_TOP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COL_TOP: state_s = ST_COL_BOT;
            ST_COL_BOT: state_s = ST_COL_DRV;
            ST_COL_DRV: state_s = ST_COL_CLK;
            ST_COL_CLK: begin
                if (col_r == COL_LAST) begin
                    state_s = ST_LATCH;
                    col_s   = COL_W'(0);
                end else begin
                    state_s = ST_COL_TOP;
                    col_s   = col_r + COL_W'(1);
                end
            end
            ST_LATCH: begin
                state_s    = ST_DISPLAY;
                disp_cnt_s = DISP_W'(0);
            end
            ST_DISPLAY: begin
                if (disp_last_s) begin
                    state_s    = ST_BLANK;
                    disp_cnt_s = DISP_W'(0);
                end else begin
                    disp_cnt_s = disp_cnt_r + DISP_W'(1);
                end
            end
            ST_BLANK: begin
                if (plane_r == PLANE_LAST) begin
                    plane_s = PLANE_W'(0);
                    if (row_r == ROW_LAST) begin
                        row_s = ROW_ADDR_W'(0);
                    end else begin
                        row_s = row_r + ROW_ADDR_W'(1);
                    end
                end else begin
                    plane_s = plane_r + PLANE_W'(1);
                end
                // Stopping only happens here, so a plane is never cut short.
                if (enable_in) begin
                    state_s = ST_COL_TOP;
                end else begin
                    state_s = ST_IDLE;
                    col_s   = COL_W'(0);
                    plane_s = PLANE_W'(0);
                    row_s   = ROW_ADDR_W'(0);
                end
            end
            default: begin
                state_s    = ST_IDLE;
                col_s      = COL_W'(0);
                plane_s    = PLANE_W'(0);
                row_s      = ROW_ADDR_W'(0);
                disp_cnt_s = DISP_W'(0);
            end
        endcase
    end

    // Output decode from the upcoming state so the registered pins align with it.
    always_comb begin
        ram_en_s     = 1'b0;
        ram_addr_s   = ram_addr_out;
        bclk_s       = 1'b0;
        lat_s        = 1'b0;
        oe_n_s       = 1'b1;
        row_addr_s   = row_addr_out;
        frame_done_s = 1'b0;
        case (state_s)
            ST_COL_TOP: begin
                ram_en_s   = 1'b1;
                ram_addr_s = top_addr_s;
            end
            ST_COL_BOT: begin
                ram_en_s   = 1'b1;
                ram_addr_s = bot_addr_s;
            end
            ST_COL_CLK: bclk_s = 1'b1;
            ST_LATCH: begin
                lat_s      = 1'b1;
                row_addr_s = row_s;
            end
            ST_DISPLAY: oe_n_s = 1'b0;
            ST_BLANK:   frame_done_s = (plane_s == PLANE_LAST) && (row_s == ROW_LAST);
            default:    ram_en_s = 1'b0;
        endcase
    end

    // Control pin registers.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            ram_en_out     <= 1'b0;
            ram_addr_out   <= 16'h0000;
            bclk_out       <= 1'b0;
            lat_out        <= 1'b0;
            oe_n_out       <= 1'b1;
            row_addr_out   <= ROW_ADDR_W'(0);
            frame_done_out <= 1'b0;
        end else begin
            ram_en_out     <= ram_en_s;
            ram_addr_out   <= ram_addr_s;
            bclk_out       <= bclk_s;
            lat_out        <= lat_s;
            oe_n_out       <= oe_n_s;
            row_addr_out   <= row_addr_s;
            frame_done_out <= frame_done_s;
        end
    end

    // Pixel capture: top word arrives during COL_BOT, bottom word during COL_DRV;
    // the colour pins change together with the rising shift clock and then hold.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            top_r  <= 24'h000000;
            r1_out <= 1'b0;
            g1_out <= 1'b0;
            b1_out <= 1'b0;
            r2_out <= 1'b0;
            g2_out <= 1'b0;
            b2_out <= 1'b0;
        end else begin
            if (state_r == ST_COL_BOT) begin
                top_r <= ram_data_in;
            end else begin
                top_r <= top_r;
            end
            if (state_r == ST_COL_DRV) begin
                r1_out <= plane_bit(top_r, 2'd2, bit_idx_s);
                g1_out <= plane_bit(top_r, 2'd1, bit_idx_s);
                b1_out <= plane_bit(top_r, 2'd0, bit_idx_s);
                r2_out <= plane_bit(ram_data_in, 2'd2, bit_idx_s);
                g2_out <= plane_bit(ram_data_in, 2'd1, bit_idx_s);
                b2_out <= plane_bit(ram_data_in, 2'd0, bit_idx_s);
            end else begin
                r1_out <= r1_out;
                g1_out <= g1_out;
                b1_out <= b1_out;
                r2_out <= r2_out;
                g2_out <= g2_out;
                b2_out <= b2_out;
            end
        end
    end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Scoreboard bench for hub75_scan_driver: a loop-level model of the scan order
// queues expected reads, shifted pixels, latches and display times; a monitor
// pops and compares them as the panel pins show activity.
module tb_hub75_scan_driver;

    localparam int W    = 4;
    localparam int RAW  = 3;
    localparam int BD   = 4;
    localparam int BT   = 2;
    localparam int SR   = 1 << RAW;
    localparam int NPIX = 2 * SR * W;

    logic           clk = 1'b0;
    logic           n_reset;
    logic           enable;
    logic           ram_en;
    logic [15:0]    ram_addr;
    logic [23:0]    ram_data;
    logic           r1, g1, b1, r2, g2, b2;
    logic           bclk, lat, oe_n;
    logic [RAW-1:0] row_addr;
    logic           frame_done;

    logic [23:0] mem [NPIX];
    int n_checks = 0;
    int n_fail   = 0;

    int         addr_q[$];
    logic [5:0] colour_q[$];
    int         latch_q[$];
    int         disp_q[$];
    logic       fd_q[$];

    always #5 clk = ~clk;

    hub75_scan_driver #(
        .PANEL_WIDTH(W), .ROW_ADDR_W(RAW), .BIT_DEPTH(BD), .BASE_TICKS(BT)
    ) dut (
        .clk_in(clk), .n_reset_in(n_reset), .enable_in(enable),
        .ram_en_out(ram_en), .ram_addr_out(ram_addr), .ram_data_in(ram_data),
        .r1_out(r1), .g1_out(g1), .b1_out(b1), .r2_out(r2), .g2_out(g2), .b2_out(b2),
        .bclk_out(bclk), .lat_out(lat), .oe_n_out(oe_n),
        .row_addr_out(row_addr), .frame_done_out(frame_done)
    );

    // Frame RAM: data valid exactly one cycle after the read, garbage otherwise.
    always @(posedge clk) begin
        if (ram_en) ram_data <= mem[int'(ram_addr) % NPIX];
        else        ram_data <= 24'($urandom);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < NPIX; i++) mem[i] = 24'($urandom);
        mem[0]      = 24'hFF0000;
        mem[SR * W] = 24'h0000FF;
        mem[1]      = 24'h804020;
    endtask

    // Reference: plane k of a run is row (k/BD)%SR, plane k%BD, columns 0..W-1.
    task automatic push_planes(input int n);
        for (int k = 0; k < n; k++) begin
            int row;
            int p;
            int b;
            row = (k / BD) % SR;
            p   = k % BD;
            b   = 8 - BD + p;
            for (int x = 0; x < W; x++) begin
                logic [23:0] t;
                logic [23:0] u;
                t = mem[row * W + x];
                u = mem[(row + SR) * W + x];
                addr_q.push_back(row * W + x);
                addr_q.push_back((row + SR) * W + x);
                colour_q.push_back({t[16 + b], t[8 + b], t[b], u[16 + b], u[8 + b], u[b]});
            end
            latch_q.push_back(row);
            disp_q.push_back(BT << p);
            fd_q.push_back((p == BD - 1) && (row == SR - 1));
        end
    endtask

    task automatic flush_model();
        addr_q.delete();
        colour_q.delete();
        latch_q.delete();
        disp_q.delete();
        fd_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check(tag, 64'({oe_n, lat, bclk, r1, g1, b1, r2, g2, b2, ram_en, ram_addr, row_addr, frame_done}),
              64'({1'b1, 9'b0, 16'h0000, RAW'(0), 1'b0}));
    endtask

    task automatic wait_latches(input int n, input int budget);
        int seen;
        int cyc;
        seen = 0;
        cyc  = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (lat) seen++;
        end
        check("latch_wait_in_budget", 64'(seen), 64'(n));
    endtask

    // Let n planes run, drop enable inside the last one's display, then idle.
    task automatic finish_run(input int n);
        int  p;
        int  d;
        int  cyc;
        bit  found;
        p = (n - 1) % BD;
        wait_latches(n, n * (4 * W + 2 + (BT << (BD - 1))) + 20);
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (!oe_n) found = 1'b1;
        end
        check("display_wait_in_budget", 64'(found), 64'(1));
        d = int'($urandom_range(0, (BT << p) - 1));
        repeat (d) @(negedge clk);
        enable = 1'b0;
        repeat (40) @(negedge clk);
        check("queues_drained", 64'(addr_q.size() + colour_q.size() + latch_q.size()
                                    + disp_q.size() + fd_q.size()), 64'(0));
        check("idle_oe_n", 64'(oe_n), 64'(1));
        check("idle_no_read", 64'(ram_en), 64'(0));
    endtask

    // Monitor: compares every pin event against the head of its expectation queue.
    initial begin
        logic       prev_bclk;
        logic       prev_oe;
        logic       prev_lat;
        int         disp_len;
        int         bclk_cnt;
        logic [5:0] exp_c;
        int         exp_i;
        logic       exp_f;
        prev_bclk = 1'b0;
        prev_oe   = 1'b1;
        prev_lat  = 1'b0;
        disp_len  = 0;
        bclk_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!n_reset) begin
                prev_bclk = 1'b0;
                prev_oe   = 1'b1;
                prev_lat  = 1'b0;
                disp_len  = 0;
                bclk_cnt  = 0;
            end else begin
                if (ram_en || bclk || lat) check("oe_blank_while_shift", 64'(oe_n), 64'(1));
                if (ram_en) begin
                    check("read_expected", 64'(addr_q.size() != 0), 64'(1));
                    if (addr_q.size() != 0) begin
                        exp_i = addr_q.pop_front();
                        check("ram_addr", 64'(ram_addr), 64'(exp_i));
                    end
                end
                if (bclk && !prev_bclk) begin
                    bclk_cnt++;
                    check("shift_expected", 64'(colour_q.size() != 0), 64'(1));
                    if (colour_q.size() != 0) begin
                        exp_c = colour_q.pop_front();
                        check("colour_bits", 64'({r1, g1, b1, r2, g2, b2}), 64'(exp_c));
                    end
                end
                if (lat) begin
                    check("latch_expected", 64'(latch_q.size() != 0), 64'(1));
                    if (latch_q.size() != 0) begin
                        exp_i = latch_q.pop_front();
                        check("latch_row", 64'(row_addr), 64'(exp_i));
                    end
                    check("bclk_per_row", 64'(bclk_cnt), 64'(W));
                    bclk_cnt = 0;
                end
                if (!oe_n) begin
                    if (prev_oe) begin
                        check("display_after_latch", 64'(prev_lat), 64'(1));
                        disp_len = 1;
                    end else begin
                        disp_len++;
                    end
                end else if (!prev_oe) begin
                    check("blank_expected", 64'(disp_q.size() != 0), 64'(1));
                    if (disp_q.size() != 0) begin
                        exp_i = disp_q.pop_front();
                        exp_f = fd_q.pop_front();
                        check("display_len", 64'(disp_len), 64'(exp_i));
                        check("frame_done", 64'(frame_done), 64'(exp_f));
                    end
                end else begin
                    check("frame_done_outside_blank", 64'(frame_done), 64'(0));
                end
                prev_bclk = bclk;
                prev_oe   = oe_n;
                prev_lat  = lat;
            end
        end
    end

    // Stimulus: long first run across a frame wrap, random runs, mid-shift reset.
    initial begin
        int k;
        int seen;
        int cyc;
        n_reset = 1'b0;
        enable  = 1'b1;
        fill_mem();
        repeat (3) @(negedge clk);
        check_reset_values("reset_outputs");

        push_planes(BD * SR + 3);
        n_reset = 1'b1;
        finish_run(BD * SR + 3);

        for (int r = 0; r < 3; r++) begin
            int n;
            n = int'($urandom_range(1, 12));
            fill_mem();
            push_planes(n);
            @(negedge clk);
            enable = 1'b1;
            finish_run(n);
        end

        fill_mem();
        push_planes(2);
        @(negedge clk);
        enable = 1'b1;
        k    = int'($urandom_range(1, 6));
        seen = 0;
        cyc  = 0;
        while (seen < k && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (bclk) seen++;
        end
        check("bclk_wait_in_budget", 64'(seen), 64'(k));
        n_reset = 1'b0;
        #1;
        check_reset_values("reset_mid_col_clk");
        repeat (3) @(negedge clk);
        check_reset_values("reset_held");
        flush_model();
        fill_mem();
        push_planes(5);
        n_reset = 1'b1;
        finish_run(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
